// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle MIPS32 datapath: fetch/decode/execute/memory/writeback
// sequencing with a bounded-wait handshake to a variable-latency memory.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_err
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [7:0] WAIT_LIM = 8'(MEM_WAIT_MAX);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait;
  logic       w_waiting;
  logic       w_timeout;

  assign state = r_state;

  // Only the three memory-handshake states accumulate wait cycles.
  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR))
                     && !mem_ready;
  assign w_timeout = w_waiting && (r_wait == WAIT_LIM);

  always_comb begin
    w_next     = S_FETCH;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_we     = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    mem_err    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        pc_we     = mem_ready;
        ir_we     = mem_ready;
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) begin
          mem_err = 1'b1;
          w_next  = S_FETCH;
        end else            w_next = S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:                      w_next = S_MEM_ADDR;
          OP_RTYPE:                          w_next = S_R_EXEC;
          OP_BEQ, OP_BNE:                    w_next = S_BRANCH;
          OP_J, OP_JAL:                      w_next = S_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next = S_I_EXEC;
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (mem_ready)      w_next = S_MEM_WB;
        else if (w_timeout) begin
          mem_err = 1'b1;
          w_next  = S_FETCH;
        end else            w_next = S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_wr     = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready)      w_next = S_FETCH;
        else if (w_timeout) begin
          mem_err = 1'b1;
          w_next  = S_FETCH;
        end else            w_next = S_MEM_WR;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_R_WB;
      end
      S_R_WB: begin
        reg_we     = 1'b1;
        reg_dst    = 2'b01;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_we      = (opcode == OP_BNE) ? ~zero : zero;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        if (opcode == OP_JAL) begin
          reg_we     = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        w_next = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        w_next    = S_I_WB;
      end
      S_I_WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wait  <= 8'd0;
    end else begin
      r_state <= w_next;
      // A timeout re-enters FETCH from FETCH, so it must clear explicitly.
      if ((w_next != r_state) || w_timeout) r_wait <= 8'd0;
      else if (w_waiting)                   r_wait <= r_wait + 8'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues hand-computed output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_we, ir_we, mem_rd, mem_wr, iord, alu_src_a, reg_we;
  logic [1:0] alu_src_b, alu_op, reg_dst, mem_to_reg, pc_src;
  logic [3:0] state;
  logic       instr_done, illegal, mem_err;

  multicycle_ctrl #(.MEM_WAIT_MAX(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_src(pc_src), .state(state),
    .instr_done(instr_done), .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Vector layout: {state, pc_we, ir_we, mem_rd, mem_wr, iord, alu_src_a,
  //                 alu_src_b, alu_op, reg_we, reg_dst, mem_to_reg, pc_src,
  //                 instr_done, illegal, mem_err}
  localparam logic [23:0] PCWE = 24'h1 << 19, IRWE = 24'h1 << 18, MRD = 24'h1 << 17;
  localparam logic [23:0] MWR = 24'h1 << 16, IORD = 24'h1 << 15, SRCA = 24'h1 << 14;
  localparam logic [23:0] B_01 = 24'h1 << 12, B_10 = 24'h2 << 12, B_11 = 24'h3 << 12;
  localparam logic [23:0] OP_SUB = 24'h1 << 10, OP_FN = 24'h2 << 10, OP_OPC = 24'h3 << 10;
  localparam logic [23:0] RWE = 24'h1 << 9, DST_RD = 24'h1 << 7, DST_31 = 24'h2 << 7;
  localparam logic [23:0] M2R_MDR = 24'h1 << 5, M2R_PC = 24'h2 << 5;
  localparam logic [23:0] PCS_OUT = 24'h1 << 3, PCS_J = 24'h2 << 3;
  localparam logic [23:0] DONE = 24'h1 << 2, ILL = 24'h1 << 1, ERR = 24'h1;

  localparam logic [23:0] E_FETCH_W  = (24'd0 << 20) | MRD | B_01;
  localparam logic [23:0] E_FETCH_R  = E_FETCH_W | PCWE | IRWE;
  localparam logic [23:0] E_FETCH_E  = E_FETCH_W | ERR;
  localparam logic [23:0] E_DECODE   = (24'd1 << 20) | B_11;
  localparam logic [23:0] E_ILLEGAL  = E_DECODE | DONE | ILL;
  localparam logic [23:0] E_MADDR    = (24'd2 << 20) | SRCA | B_10;
  localparam logic [23:0] E_MRD      = (24'd3 << 20) | MRD | IORD;
  localparam logic [23:0] E_MRD_E    = E_MRD | ERR;
  localparam logic [23:0] E_MWB      = (24'd4 << 20) | RWE | M2R_MDR | DONE;
  localparam logic [23:0] E_MWR_W    = (24'd5 << 20) | MWR | IORD;
  localparam logic [23:0] E_MWR_R    = E_MWR_W | DONE;
  localparam logic [23:0] E_REX      = (24'd6 << 20) | SRCA | OP_FN;
  localparam logic [23:0] E_RWB      = (24'd7 << 20) | RWE | DST_RD | DONE;
  localparam logic [23:0] E_BR_N     = (24'd8 << 20) | SRCA | OP_SUB | PCS_OUT | DONE;
  localparam logic [23:0] E_BR_T     = E_BR_N | PCWE;
  localparam logic [23:0] E_J        = (24'd9 << 20) | PCWE | PCS_J | DONE;
  localparam logic [23:0] E_JAL      = E_J | RWE | DST_31 | M2R_PC;
  localparam logic [23:0] E_IEX      = (24'd10 << 20) | SRCA | B_10 | OP_OPC;
  localparam logic [23:0] E_IWB      = (24'd11 << 20) | RWE | DONE;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, ADDI = 6'b001000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010, JAL = 6'b000011;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    string       name;
    logic [23:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t        e;
      logic [23:0] act;
      e   = sb_q.pop_front();
      act = {state, pc_we, ir_we, mem_rd, mem_wr, iord, alu_src_a, alu_src_b, alu_op,
             reg_we, reg_dst, mem_to_reg, pc_src, instr_done, illegal, mem_err};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %06h expected %06h", e.name, act, e.exp);
      end
    end
  end

  // Drive one cycle's inputs just after the edge and queue the expected outputs.
  task automatic step(input string name, input logic r, input logic [5:0] opc,
                      input logic z, input logic rdy, input logic [23:0] exp);
    @(posedge clk);
    #1;
    rst       = r;
    opcode    = opc;
    zero      = z;
    mem_ready = rdy;
    sb_q.push_back('{name, exp});
  endtask

  initial begin
    step("reset",        1, LW,   0, 0, E_FETCH_W);
    // lw, no waits: 0,1,2,3,4
    step("lw_fetch",     0, LW,   0, 1, E_FETCH_R);
    step("lw_decode",    0, LW,   0, 1, E_DECODE);
    step("lw_maddr",     0, LW,   0, 1, E_MADDR);
    step("lw_mrd",       0, LW,   0, 1, E_MRD);
    step("lw_mwb",       0, LW,   0, 1, E_MWB);
    // sw with two wait cycles in MEM_WR
    step("sw_fetch",     0, SW,   0, 1, E_FETCH_R);
    step("sw_decode",    0, SW,   0, 1, E_DECODE);
    step("sw_maddr",     0, SW,   0, 0, E_MADDR);
    step("sw_wait1",     0, SW,   0, 0, E_MWR_W);
    step("sw_wait2",     0, SW,   0, 0, E_MWR_W);
    step("sw_done",      0, SW,   0, 1, E_MWR_R);
    // R-type and I-type
    step("r_fetch",      0, RT,   0, 1, E_FETCH_R);
    step("r_decode",     0, RT,   0, 1, E_DECODE);
    step("r_exec",       0, RT,   0, 1, E_REX);
    step("r_wb",         0, RT,   0, 1, E_RWB);
    step("i_fetch",      0, ADDI, 0, 1, E_FETCH_R);
    step("i_decode",     0, ADDI, 0, 1, E_DECODE);
    step("i_exec",       0, ADDI, 0, 1, E_IEX);
    step("i_wb",         0, ADDI, 0, 1, E_IWB);
    // branches
    step("beq1_fetch",   0, BEQ,  1, 1, E_FETCH_R);
    step("beq1_decode",  0, BEQ,  1, 1, E_DECODE);
    step("beq_taken",    0, BEQ,  1, 1, E_BR_T);
    step("beq0_fetch",   0, BEQ,  0, 1, E_FETCH_R);
    step("beq0_decode",  0, BEQ,  0, 1, E_DECODE);
    step("beq_not",      0, BEQ,  0, 1, E_BR_N);
    step("bne0_fetch",   0, BNE,  0, 1, E_FETCH_R);
    step("bne0_decode",  0, BNE,  0, 1, E_DECODE);
    step("bne_taken",    0, BNE,  0, 1, E_BR_T);
    step("bne1_fetch",   0, BNE,  1, 1, E_FETCH_R);
    step("bne1_decode",  0, BNE,  1, 1, E_DECODE);
    step("bne_not",      0, BNE,  1, 1, E_BR_N);
    // jumps
    step("jal_fetch",    0, JAL,  0, 1, E_FETCH_R);
    step("jal_decode",   0, JAL,  0, 1, E_DECODE);
    step("jal_jump",     0, JAL,  0, 1, E_JAL);
    step("j_fetch",      0, J,    0, 1, E_FETCH_R);
    step("j_decode",     0, J,    0, 1, E_DECODE);
    step("j_jump",       0, J,    0, 1, E_J);
    // illegal opcode
    step("bad_fetch",    0, BAD,  0, 1, E_FETCH_R);
    step("bad_decode",   0, BAD,  0, 1, E_ILLEGAL);
    // MEM_RD timeout at count 3, then fetch timeout confirms the counter restarted
    step("lwto_fetch",   0, LW,   0, 1, E_FETCH_R);
    step("lwto_decode",  0, LW,   0, 1, E_DECODE);
    step("lwto_maddr",   0, LW,   0, 0, E_MADDR);
    step("lwto_w0",      0, LW,   0, 0, E_MRD);
    step("lwto_w1",      0, LW,   0, 0, E_MRD);
    step("lwto_w2",      0, LW,   0, 0, E_MRD);
    step("lwto_err",     0, LW,   0, 0, E_MRD_E);
    step("fto_w0",       0, LW,   0, 0, E_FETCH_W);
    step("fto_w1",       0, LW,   0, 0, E_FETCH_W);
    step("fto_w2",       0, LW,   0, 0, E_FETCH_W);
    step("fto_err",      0, LW,   0, 0, E_FETCH_E);
    // mem_ready on the limit cycle completes normally
    step("lim_fetch",    0, LW,   0, 1, E_FETCH_R);
    step("lim_decode",   0, LW,   0, 1, E_DECODE);
    step("lim_maddr",    0, LW,   0, 0, E_MADDR);
    step("lim_w0",       0, LW,   0, 0, E_MRD);
    step("lim_w1",       0, LW,   0, 0, E_MRD);
    step("lim_w2",       0, LW,   0, 0, E_MRD);
    step("lim_ready",    0, LW,   0, 1, E_MRD);
    step("lim_mwb",      0, LW,   0, 1, E_MWB);
    // asynchronous reset in the middle of MEM_WR
    step("rsw_fetch",    0, SW,   0, 1, E_FETCH_R);
    step("rsw_decode",   0, SW,   0, 1, E_DECODE);
    step("rsw_maddr",    0, SW,   0, 0, E_MADDR);
    step("rsw_w0",       0, SW,   0, 0, E_MWR_W);
    step("rsw_w1",       0, SW,   0, 0, E_MWR_W);
    step("rsw_reset",    1, SW,   0, 0, E_FETCH_W);
    // counter must restart from zero after reset: three waits, no error
    step("rst_fw0",      0, RT,   0, 0, E_FETCH_W);
    step("rst_fw1",      0, RT,   0, 0, E_FETCH_W);
    step("rst_fw2",      0, RT,   0, 0, E_FETCH_W);
    step("rst_fready",   0, RT,   0, 1, E_FETCH_R);
    step("rst_decode",   0, RT,   0, 1, E_DECODE);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
